// File: rtl/rs232_frame_rx_if.sv
// Byte-in / write-out bundle of the RS-232 frame controller.
// master = frame controller side, slave = receiver plus register/LED logic side.
`timescale 1ns/1ps
interface rs232_frame_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rs232_ctsn;
    logic [7:0] out_addr;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       frame_ok;
    logic       frame_err;
    logic       overrun;

    modport master (
        input  rx_data, rx_valid, out_ready,
        output rs232_ctsn, out_addr, out_data, out_valid, frame_ok, frame_err, overrun
    );

    modport slave (
        output rx_data, rx_valid, out_ready,
        input  rs232_ctsn, out_addr, out_data, out_valid, frame_ok, frame_err, overrun
    );
endinterface

// File: rtl/rs232_frame_rx.sv
// Parses sync/addr/len/payload/xor-checksum frames and replays a verified payload as addressed writes.
// Status pulses one cycle after the deciding byte; out_ready stalls the drain, CTS pauses the host meanwhile.
`timescale 1ns/1ps
module rs232_frame_rx #(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned TIMEOUT = 133000,
    parameter logic [7:0]  SYNC    = 8'hA5
) (
    input  logic             clock,
    input  logic             resetn,
    rs232_frame_rx_if.master bus
);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned AW = (MAX_LEN < 2) ? 1 : $clog2(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_LEN, S_DATA, S_CSUM, S_DRAIN
    } state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] timer;
    logic [7:0]    base, len, csum, idx;
    logic [7:0]    idx_inc;
    logic [7:0]    buf_mem [MAX_LEN];
    logic          ok_set, err_set, ovr_set;
    logic          timed, expire, xfer, last_xfer;

    assign idx_inc   = idx + 8'd1;
    assign timed     = (state == S_ADDR) || (state == S_LEN) ||
                       (state == S_DATA) || (state == S_CSUM);
    // A byte arriving in the expiry cycle takes precedence over the abort.
    assign expire    = timed && !bus.rx_valid && (timer == TW'(TIMEOUT - 1));
    assign xfer      = bus.out_valid && bus.out_ready;
    assign last_xfer = xfer && (idx_inc == len);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ok_set    = 1'b0;
        err_set   = 1'b0;
        ovr_set   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.rx_valid && bus.rx_data == SYNC) state_nxt = S_ADDR;
            end
            S_ADDR: begin
                if (bus.rx_valid) state_nxt = S_LEN;
                else if (expire) begin
                    state_nxt = S_IDLE;
                    err_set   = 1'b1;
                end
            end
            S_LEN: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data > 8'(MAX_LEN)) begin
                        state_nxt = S_IDLE;
                        err_set   = 1'b1;
                    end else if (bus.rx_data == 8'd0) begin
                        state_nxt = S_CSUM;
                    end else begin
                        state_nxt = S_DATA;
                    end
                end else if (expire) begin
                    state_nxt = S_IDLE;
                    err_set   = 1'b1;
                end
            end
            S_DATA: begin
                if (bus.rx_valid) begin
                    if (idx_inc == len) state_nxt = S_CSUM;
                end else if (expire) begin
                    state_nxt = S_IDLE;
                    err_set   = 1'b1;
                end
            end
            S_CSUM: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == csum) begin
                        ok_set    = 1'b1;
                        state_nxt = (len == 8'd0) ? S_IDLE : S_DRAIN;
                    end else begin
                        err_set   = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end else if (expire) begin
                    state_nxt = S_IDLE;
                    err_set   = 1'b1;
                end
            end
            S_DRAIN: begin
                ovr_set = bus.rx_valid;
                if (last_xfer) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            timer          <= '0;
            base           <= 8'd0;
            len            <= 8'd0;
            csum           <= 8'd0;
            idx            <= 8'd0;
            bus.rs232_ctsn <= 1'b0;
            bus.out_valid  <= 1'b0;
            bus.out_addr   <= 8'd0;
            bus.out_data   <= 8'd0;
            bus.frame_ok   <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.overrun    <= 1'b0;
        end else begin
            bus.frame_ok   <= ok_set;
            bus.frame_err  <= err_set;
            bus.overrun    <= ovr_set;
            bus.rs232_ctsn <= (state_nxt == S_DRAIN);
            timer          <= (timed && !bus.rx_valid) ? timer + 1'b1 : '0;
            if (bus.rx_valid) begin
                case (state)
                    S_ADDR: begin
                        base <= bus.rx_data;
                        csum <= bus.rx_data;
                    end
                    S_LEN: begin
                        len  <= bus.rx_data;
                        csum <= csum ^ bus.rx_data;
                        idx  <= 8'd0;
                    end
                    S_DATA: begin
                        csum <= csum ^ bus.rx_data;
                        idx  <= idx_inc;
                    end
                    S_CSUM:  idx <= 8'd0;
                    default: ;
                endcase
            end
            // First element goes out the cycle after entry; later ones follow each accepted transfer.
            if (state == S_DRAIN) begin
                if (!bus.out_valid) begin
                    bus.out_valid <= 1'b1;
                    bus.out_addr  <= base + idx;
                    bus.out_data  <= buf_mem[idx[AW-1:0]];
                end else if (bus.out_ready) begin
                    if (idx_inc == len) begin
                        bus.out_valid <= 1'b0;
                    end else begin
                        idx          <= idx_inc;
                        bus.out_addr <= base + idx_inc;
                        bus.out_data <= buf_mem[idx_inc[AW-1:0]];
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (state == S_DATA && bus.rx_valid) buf_mem[idx[AW-1:0]] <= bus.rx_data;
    end
endmodule

// File: tb/tb_rs232_frame_rx.sv
// Table-driven, directed and randomized checks of rs232_frame_rx against a frame-level stream model.
`timescale 1ns/1ps
module tb_rs232_frame_rx;
    localparam int         TO = 40;
    localparam int         ML = 16;
    localparam logic [7:0] SY = 8'hA5;
    localparam int         NV = 8;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    rs232_frame_rx_if bus();

    rs232_frame_rx #(.MAX_LEN(ML), .TIMEOUT(TO), .SYNC(SY)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        logic [7:0]  b [8];
        int          nb;
        int          ok;
        int          err;
        int          nw;
        logic [15:0] w [4];
    } vec_t;

    vec_t        vt [NV];
    int          n_chk = 0, n_fail = 0;
    int          ok_cnt = 0, err_cnt = 0, ovr_cnt = 0, viol_cnt = 0;
    logic [15:0] wq [$];
    logic        prev_stall = 1'b0, prev_ok = 1'b0, prev_err = 1'b0;
    logic [7:0]  p_addr = 8'd0, p_data = 8'd0;
    bit          rand_ready = 1'b0;
    int          host_to = 0;
    logic [7:0]  sent [$];

    // Passive monitor: counts pulses, records transfers, flags protocol violations.
    always @(negedge clock) begin
        if (!resetn) begin
            prev_stall = 1'b0;
            prev_ok    = 1'b0;
            prev_err   = 1'b0;
        end else begin
            if (bus.frame_ok)  ok_cnt++;
            if (bus.frame_err) err_cnt++;
            if (bus.overrun)   ovr_cnt++;
            if (bus.frame_ok && bus.frame_err) viol_cnt++;
            if ((bus.frame_ok && prev_ok) || (bus.frame_err && prev_err)) viol_cnt++;
            if (prev_stall && (!bus.out_valid || bus.out_addr != p_addr || bus.out_data != p_data))
                viol_cnt++;
            if (bus.out_valid && bus.out_ready) wq.push_back({bus.out_addr, bus.out_data});
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_ok    = bus.frame_ok;
            prev_err   = bus.frame_err;
            p_addr     = bus.out_addr;
            p_data     = bus.out_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.rx_valid = 1'b0;
        if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    // Host behaviour: random idle gap, then honours CTS before sending.
    task automatic host(input logic [7:0] b);
        int gap;
        gap = $urandom_range(0, 3);
        repeat (gap) step();
        for (int k = 0; k < 300 && bus.rs232_ctsn; k++) step();
        if (bus.rs232_ctsn) host_to++;
        send(b);
        sent.push_back(b);
    endtask

    task automatic wait_quiet(input string name);
        for (int k = 0; k < 300; k++) begin
            if (!bus.rs232_ctsn && !bus.out_valid) break;
            step();
        end
        chk({name, "_drain_done"}, {30'd0, bus.rs232_ctsn, bus.out_valid}, 0);
        repeat (3) step();
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_ctsn"},      bus.rs232_ctsn, 0);
        chk({name, "_out_valid"}, bus.out_valid, 0);
        chk({name, "_out_addr"},  bus.out_addr, 0);
        chk({name, "_out_data"},  bus.out_data, 0);
        chk({name, "_frame_ok"},  bus.frame_ok, 0);
        chk({name, "_frame_err"}, bus.frame_err, 0);
        chk({name, "_overrun"},   bus.overrun, 0);
    endtask

    task automatic send_nominal();
        send(8'hA5); send(8'h10); send(8'h02); send(8'h11); send(8'h22); send(8'h21);
    endtask

    // Frame-level reference: walks the byte stream and applies the framing rules directly.
    function automatic void model(input logic [7:0] s [$], output int ok, output int err,
                                  output logic [15:0] w [$]);
        int         i, n, l;
        logic [7:0] base, x;
        ok = 0; err = 0; w.delete();
        n = s.size();
        i = 0;
        while (i < n) begin
            if (s[i] != SY) begin i++; continue; end
            if (i + 2 >= n) begin err++; break; end
            base = s[i+1];
            l    = int'(s[i+2]);
            if (l > ML) begin err++; i += 3; continue; end
            if (i + 3 + l >= n) begin err++; break; end
            x = base ^ s[i+2];
            for (int k = 0; k < l; k++) x ^= s[i+3+k];
            if (x == s[i+3+l]) begin
                ok++;
                for (int k = 0; k < l; k++) w.push_back({8'(base + 8'(k)), s[i+3+k]});
            end else begin
                err++;
            end
            i += 4 + l;
        end
    endfunction

    initial begin
        int          ok0, err0, ovr0, sb, n, eok, eerr;
        logic [15:0] ew [$];
        logic [7:0]  base, len, cs, d, b;

        vt[0] = '{b:'{8'hA5,8'h10,8'h02,8'h11,8'h22,8'h21,0,0}, nb:6, ok:1, err:0, nw:2, w:'{16'h1011,16'h1122,0,0}};
        vt[1] = '{b:'{8'hA5,8'h10,8'h02,8'h11,8'h22,8'h20,0,0}, nb:6, ok:0, err:1, nw:0, w:'{0,0,0,0}};
        vt[2] = '{b:'{8'hA5,8'h10,8'h11,0,0,0,0,0},             nb:3, ok:0, err:1, nw:0, w:'{0,0,0,0}};
        vt[3] = vt[0];
        vt[4] = '{b:'{8'h00,8'h5A,8'hA5,8'hFF,8'h00,8'hFF,0,0}, nb:6, ok:1, err:0, nw:0, w:'{0,0,0,0}};
        vt[5] = '{b:'{8'hA5,8'hFF,8'h02,8'h01,8'h02,8'hFE,0,0}, nb:6, ok:1, err:0, nw:2, w:'{16'hFF01,16'h0002,0,0}};
        vt[6] = '{b:'{8'hA5,8'hFF,8'h02,8'h01,8'h02,8'hFC,0,0}, nb:6, ok:0, err:1, nw:0, w:'{0,0,0,0}};
        vt[7] = '{b:'{8'hA5,8'h12,8'h03,8'hA5,8'h00,8'h7E,8'hCA,0}, nb:7, ok:1, err:0, nw:3,
                  w:'{16'h12A5,16'h1300,16'h147E,0}};

        bus.rx_valid  = 1'b0;
        bus.rx_data   = 8'd0;
        bus.out_ready = 1'b1;
        #1;
        chk_reset("reset");
        repeat (3) @(posedge clock);
        #1;
        resetn = 1'b1;
        step();

        // Nominal frame, cycle by cycle.
        sb = wq.size();
        send_nominal();
        chk("nom_ok_pulse", bus.frame_ok, 1);
        chk("nom_ctsn_on", bus.rs232_ctsn, 1);
        chk("nom_valid_delay", bus.out_valid, 0);
        step();
        chk("nom_w0", {bus.out_valid, bus.out_addr, bus.out_data}, {1'b1, 16'h1011});
        step();
        chk("nom_w1", {bus.out_valid, bus.out_addr, bus.out_data}, {1'b1, 16'h1122});
        chk("nom_ctsn_hold", bus.rs232_ctsn, 1);
        step();
        chk("nom_end", {bus.out_valid, bus.rs232_ctsn}, 0);
        chk("nom_nwrites", wq.size() - sb, 2);

        for (int v = 0; v < NV; v++) begin
            ok0 = ok_cnt; err0 = err_cnt; sb = wq.size();
            for (int k = 0; k < vt[v].nb; k++) send(vt[v].b[k]);
            wait_quiet($sformatf("vec%0d", v));
            chk($sformatf("vec%0d_ok", v), ok_cnt - ok0, vt[v].ok);
            chk($sformatf("vec%0d_err", v), err_cnt - err0, vt[v].err);
            chk($sformatf("vec%0d_nw", v), wq.size() - sb, vt[v].nw);
            for (int k = 0; k < vt[v].nw; k++)
                if (sb + k < wq.size()) chk($sformatf("vec%0d_w%0d", v, k), wq[sb+k], vt[v].w[k]);
        end

        // Timeout latency measured from the address byte.
        err0 = err_cnt;
        send(8'hA5); send(8'h10);
        n = 0;
        for (int k = 1; k <= 2 * TO; k++) begin
            step();
            if (bus.frame_err) begin n = k; break; end
        end
        chk("timeout_latency", n, TO);
        ok0 = ok_cnt;
        send(8'hA5); send(8'h10); send(8'h00); send(8'h10);
        wait_quiet("post_timeout");
        chk("post_timeout_ok", ok_cnt - ok0, 1);
        chk("timeout_err_count", err_cnt - err0, 1);

        // Bytes just before and exactly at the expiry cycle keep the frame alive.
        for (int m = TO - 2; m <= TO - 1; m++) begin
            ok0 = ok_cnt; err0 = err_cnt;
            send(8'hA5); send(8'h10);
            repeat (m) step();
            send(8'h00); send(8'h10);
            wait_quiet($sformatf("late%0d", m));
            chk($sformatf("late%0d_err", m), err_cnt - err0, 0);
            chk($sformatf("late%0d_ok", m), ok_cnt - ok0, 1);
        end

        // Back-pressure and overrun.
        ok0 = ok_cnt; err0 = err_cnt; ovr0 = ovr_cnt; sb = wq.size();
        bus.out_ready = 1'b0;
        send_nominal();
        for (int k = 0; k < 10 && !bus.out_valid; k++) step();
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("stall%0d", k), {bus.out_valid, bus.rs232_ctsn, bus.out_addr, bus.out_data},
                {2'b11, 16'h1011});
        end
        send(8'h33);
        chk("overrun_pulse", bus.overrun, 1);
        chk("overrun_hold", {bus.out_valid, bus.out_addr, bus.out_data}, {1'b1, 16'h1011});
        bus.out_ready = 1'b1;
        wait_quiet("bp");
        chk("bp_nw", wq.size() - sb, 2);
        if (wq.size() >= sb + 2) begin
            chk("bp_w0", wq[sb], 16'h1011);
            chk("bp_w1", wq[sb+1], 16'h1122);
        end
        chk("bp_ovr_count", ovr_cnt - ovr0, 1);
        chk("bp_ok_err", {ok_cnt - ok0, err_cnt - err0}, {32'd1, 32'd0});

        // Reset mid-DATA and mid-DRAIN.
        ok0 = ok_cnt; err0 = err_cnt;
        send(8'hA5); send(8'h10); send(8'h02); send(8'h11);
        resetn = 1'b0;
        #1;
        chk_reset("rst_data");
        step();
        resetn = 1'b1;
        step();
        bus.out_ready = 1'b0;
        send_nominal();
        repeat (3) step();
        chk("pre_rst_valid", bus.out_valid, 1);
        ok0 = ok_cnt; err0 = err_cnt;
        resetn = 1'b0;
        #1;
        chk_reset("rst_drain");
        step(); step();
        resetn = 1'b1;
        bus.out_ready = 1'b1;
        repeat (TO + 5) step();
        chk("rst_no_pulse", {ok_cnt - ok0, err_cnt - err0}, 0);
        ok0 = ok_cnt; sb = wq.size();
        send_nominal();
        wait_quiet("post_rst");
        chk("post_rst_ok", ok_cnt - ok0, 1);
        chk("post_rst_nw", wq.size() - sb, 2);
        if (wq.size() >= sb + 2) chk("post_rst_w", {wq[sb], wq[sb+1]}, {16'h1011, 16'h1122});

        // Randomized frames against the stream model.
        ok0 = ok_cnt; err0 = err_cnt; sb = wq.size();
        rand_ready = 1'b1;
        for (int f = 0; f < 25; f++) begin
            n = $urandom_range(0, 2);
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom_range(0, 255));
                if (b == SY) b = 8'h00;
                host(b);
            end
            host(SY);
            base = 8'($urandom_range(0, 255));
            host(base);
            if ($urandom_range(0, 9) == 0) begin
                host(8'($urandom_range(ML + 1, 255)));
                continue;
            end
            len = 8'($urandom_range(0, ML));
            host(len);
            cs = base ^ len;
            for (int k = 0; k < int'(len); k++) begin
                d = 8'($urandom_range(0, 255));
                cs ^= d;
                host(d);
            end
            if ($urandom_range(0, 4) == 0) cs ^= 8'(1 << $urandom_range(0, 7));
            host(cs);
        end
        rand_ready = 1'b0;
        bus.out_ready = 1'b1;
        wait_quiet("rand");
        repeat (TO + 5) step();
        model(sent, eok, eerr, ew);
        chk("rand_ok", ok_cnt - ok0, eok);
        chk("rand_err", err_cnt - err0, eerr);
        chk("rand_nw", wq.size() - sb, ew.size());
        for (int k = 0; k < ew.size(); k++)
            if (sb + k < wq.size()) chk($sformatf("rand_w%0d", k), wq[sb+k], ew[k]);

        chk("host_cts_wait", host_to, 0);
        chk("monitor_violations", viol_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end
endmodule
